// File: rtl/wm_pkg.sv
// Shared constants and width helpers for the watermark blend datapath.
// SCALE is the fixed-point unit shared with the downstream divide stage.
package wm_pkg;

    localparam int unsigned SCALE      = 1000000;
    localparam int unsigned DATA_DEPTH = 8;
    localparam int unsigned IMG_SIZE   = 65536;

    function automatic int unsigned coef_width(input int unsigned dd);
        return 3 * dd;
    endfunction

    function automatic int unsigned out_width(input int unsigned dd);
        return 4 * dd;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/wm_pipe_reg.sv
// Single valid/ready register slice without skid buffer; ready passes
// combinationally from downstream so back-to-back transfers have no bubbles.
module wm_pipe_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         up_valid,
    output logic         up_ready_c,
    input  logic [W-1:0] up_data,
    output logic         dn_valid,
    input  logic         dn_ready,
    output logic [W-1:0] dn_data
);

    assign up_ready_c = !dn_valid || dn_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready_c) begin
            dn_valid <= up_valid;
            if (up_valid) begin
                dn_data <= up_data;
            end
        end
    end

endmodule

// File: rtl/watermark_blend_mac.sv
// Two-stage multiply-accumulate computing alpha*host + beta*mark (unscaled),
// with frame-synchronous coefficient swap, frame pixel counter and sticky saturation.
module watermark_blend_mac
    import wm_pkg::*;
#(
    parameter int unsigned Data_Depth = DATA_DEPTH,
    parameter int unsigned Coef_Width = 3 * Data_Depth,
    parameter int unsigned Img_Size   = IMG_SIZE
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      coef_wr,
    input  logic [Coef_Width-1:0]     coef_alpha,
    input  logic [Coef_Width-1:0]     coef_beta,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic                      in_sof,
    input  logic [Data_Depth-1:0]     host_pix,
    input  logic [Data_Depth-1:0]     mark_pix,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [4*Data_Depth-1:0]   prod1,
    output logic                      out_eof,
    output logic                      sat_flag
);

    localparam int unsigned PROD_W = Data_Depth + Coef_Width;
    localparam int unsigned OUT_W  = out_width(Data_Depth);
    localparam int unsigned ACC_W  = (PROD_W + 1 > OUT_W) ? PROD_W + 1 : OUT_W + 1;
    localparam int unsigned CNT_W  = cnt_width(Img_Size);
    localparam int unsigned S1_W   = 2 * PROD_W + 1;
    localparam int unsigned S2_W   = OUT_W + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Img_Size - 1);

    logic                  run;
    logic                  accept_c;
    logic                  sof_acc_c;
    logic [Coef_Width-1:0] alpha_sh;
    logic [Coef_Width-1:0] beta_sh;
    logic [Coef_Width-1:0] alpha_act;
    logic [Coef_Width-1:0] beta_act;
    logic [Coef_Width-1:0] alpha_use_c;
    logic [Coef_Width-1:0] beta_use_c;
    logic [CNT_W-1:0]      count;
    logic                  eof_c;
    logic [PROD_W-1:0]     pa_c;
    logic [PROD_W-1:0]     pb_c;
    logic [S1_W-1:0]       s1_in_c;
    logic [S1_W-1:0]       s1_data;
    logic                  s1_valid;
    logic                  s1_ready_c;
    logic                  s2_ready_c;
    logic                  s1_eof;
    logic [PROD_W-1:0]     s1_pa;
    logic [PROD_W-1:0]     s1_pb;
    logic [ACC_W-1:0]      sum_c;
    logic                  sat_c;
    logic [OUT_W-1:0]      prod_c;
    logic [S2_W-1:0]       s2_in_c;
    logic [S2_W-1:0]       s2_data;

    // Input side: an sof pixel bypasses the active set and uses the freshest coefficients.
    always_comb begin
        alpha_use_c = alpha_act;
        beta_use_c  = beta_act;
        if (in_sof) begin
            alpha_use_c = coef_wr ? coef_alpha : alpha_sh;
            beta_use_c  = coef_wr ? coef_beta  : beta_sh;
        end
        accept_c  = in_valid && in_ready;
        sof_acc_c = accept_c && in_sof;
        eof_c     = !in_sof && (count == CNT_LAST);
        pa_c      = PROD_W'(alpha_use_c) * PROD_W'(host_pix);
        pb_c      = PROD_W'(beta_use_c) * PROD_W'(mark_pix);
        s1_in_c   = {eof_c, pa_c, pb_c};
    end

    assign in_ready = run && s1_ready_c;
    assign {s1_eof, s1_pa, s1_pb} = s1_data;

    always_comb begin
        sum_c   = ACC_W'(s1_pa) + ACC_W'(s1_pb);
        sat_c   = |sum_c[ACC_W-1:OUT_W];
        prod_c  = sat_c ? '1 : sum_c[OUT_W-1:0];
        s2_in_c = {s1_eof, prod_c};
    end

    assign {out_eof, prod1} = s2_data;

    wm_pipe_reg #(.W(S1_W)) u_s1 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (in_valid && run),
        .up_ready_c (s1_ready_c),
        .up_data    (s1_in_c),
        .dn_valid   (s1_valid),
        .dn_ready   (s2_ready_c),
        .dn_data    (s1_data)
    );

    wm_pipe_reg #(.W(S2_W)) u_s2 (
        .clk        (clk),
        .rst        (rst),
        .up_valid   (s1_valid),
        .up_ready_c (s2_ready_c),
        .up_data    (s2_in_c),
        .dn_valid   (out_valid),
        .dn_ready   (out_ready),
        .dn_data    (s2_data)
    );

    // Holds in_ready low until the first clock edge after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
        end else begin
            run <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alpha_sh  <= '0;
            beta_sh   <= '0;
            alpha_act <= '0;
            beta_act  <= '0;
        end else begin
            if (coef_wr) begin
                alpha_sh <= coef_alpha;
                beta_sh  <= coef_beta;
            end
            if (sof_acc_c) begin
                alpha_act <= alpha_use_c;
                beta_act  <= beta_use_c;
            end
        end
    end

    // Frame counter: sof restarts at 1, the last position wraps to 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (accept_c) begin
            if (in_sof) begin
                count <= CNT_W'(1);
            end else if (count == CNT_LAST) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

    // A new frame clears the flag before any older saturating pixel can set it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
        end else if (sof_acc_c) begin
            sat_flag <= 1'b0;
        end else if (s1_valid && s2_ready_c && sat_c) begin
            sat_flag <= 1'b1;
        end
    end

endmodule

// File: doc/watermark_blend_mac.md
Name: watermark_blend_mac

Overview:
- Pipelined multiply-accumulate stage that computes the unscaled blend product prod1 = alpha*host + beta*mark.
- Sits directly upstream of the divide-by-1,000,000 stage. Coefficients are fixed-point values scaled by 10^6 (1.0 = 1,000,000).
- Has a valid/ready stream on both sides, coefficient shadow registers that swap atomically at frame start, a per-frame pixel counter and a sticky saturation flag.

Parameters:
- Data_Depth, 8, pixel width in bits. Output width is 4*Data_Depth.
- Coef_Width, 3*Data_Depth, coefficient width. Unsigned, scaled by 10^6.
- Img_Size, 65536, pixels per frame. The counter width is clog2(Img_Size).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- coef_wr  in  1  load shadow coefficients this cycle.
- coef_alpha  in  Coef_Width  host weight, x10^6.
- coef_beta  in  Coef_Width  watermark weight, x10^6.
- in_valid  in  1  input pixel pair valid.
- in_ready  out  1  block accepts the pair this cycle.
- in_sof  in  1  first pixel of a frame; qualified by in_valid.
- host_pix  in  Data_Depth  host image pixel.
- mark_pix  in  Data_Depth  watermark pixel.
- out_valid  out  1  prod1 valid.
- out_ready  in  1  downstream divider accepts.
- prod1  out  4*Data_Depth  alpha*host + beta*mark, saturated.
- out_eof  out  1  marks the last pixel of the frame; qualified by out_valid.
- sat_flag  out  1  sticky: saturation occurred in the current frame.

Behaviour:
- Reset (rst=0, asynchronous):
  - in_ready=0 while rst=0, then 1 from the first clock after release.
  - out_valid=0, prod1=0, out_eof=0, sat_flag=0.
  - Shadow and active coefficients = 0. Pixel counter = 0. Both pipeline stages empty.
- Reset mid-operation discards in-flight data; no partial output is produced.
- Handshakes:
  - Input transfer occurs when in_valid & in_ready. Output transfer occurs when out_valid & out_ready.
  - out_valid is held and prod1/out_eof stay stable until accepted.
- Pipeline: two register stages, latency exactly 2 cycles from input accept to out_valid when not stalled.
  - S1 registers p_a = alpha_act*host_pix and p_b = beta_act*mark_pix, each Data_Depth+Coef_Width bits, plus the eof tag.
  - S2 registers sum = p_a + p_b at full width.
  - If sum >= 2^(4*Data_Depth), prod1 = all ones and sat_flag is set. Otherwise prod1 = sum truncated to 4*Data_Depth bits.
- Flow control:
  - S2 loads when S2 is empty or out_ready. S1 loads when S1 is empty or S2 loads.
  - in_ready = S1 empty or S2 loads. This is combinational from out_ready; there are no bubbles, so throughput is 1 pixel/cycle.
- Coefficients:
  - coef_wr writes the shadow registers.
  - Active registers take the shadow values when an in_sof pixel is accepted, and that pixel already uses the new values.
  - If coef_wr and the in_sof accept occur in the same cycle, the new coef_alpha/coef_beta inputs are used directly for that pixel.
- Pixel counter:
  - Increments per accepted pixel. An accepted in_sof forces count to 1.
  - The pixel accepted at count == Img_Size-1 is tagged eof; the counter then wraps to 0.
  - An in_sof arriving before the count completes restarts the counter and does not tag eof on the previous pixel.
- sat_flag clears on an accepted in_sof, unless that same pixel saturates in S2, in which case it sets.
  - Clear takes priority at acceptance time. The set is applied when the saturating pixel reaches S2.

Decomposition:
- Shared package (wm_pkg) holds:
  - SCALE = 1000000 (shared with the divider stage).
  - Default Data_Depth.
  - Widths derived from Data_Depth.
- One natural sub-module, wm_pipe_reg: a valid/ready skid-less register slice, instantiated twice for S1 and S2.

Test Plan:
- Basic product:
  - Setup: alpha=700000, beta=300000 loaded with coef_wr, then in_sof with host=200, mark=100.
  - Expected: prod1=170000000 two cycles after accept, out_eof=0.
- Frame swap:
  - Setup: coef_wr alpha=1000000, beta=0 in mid-frame.
  - Expected: following non-sof pixels still use the old coefficients. The next in_sof pixel host=50, mark=255 gives prod1=50000000.
- Backpressure:
  - Setup: stream 10 pixels with out_ready toggled 1,0,0,1,...
  - Expected: every prod1 delivered once, in order, with no loss or duplication. in_ready drops only when both stages are full and out_ready=0.
- Saturation:
  - Setup: Data_Depth=8, alpha=beta=16777215, host=mark=255.
  - Expected: prod1=32'hFFFFFFFF and sat_flag=1. sat_flag stays 1 until the next in_sof, which clears it when its product fits.
- Frame end:
  - Setup: Img_Size=4, four pixels starting with in_sof.
  - Expected: the fourth output has out_eof=1. A fifth pixel without sof gets counter 1 and no eof.
- Reset mid-stream:
  - Setup: assert rst with both stages full.
  - Expected: out_valid=0 and in_ready=0 immediately, independent of clk. After release, the first output comes only from newly accepted input.
